fetch_redirect: RTL and testbench
=================================

// Module: fetch_redirect
// PURPOSE
//  IF-stage PC sequencer: consumes the taken/not-taken decision from the ID-stage branch comparator and
//  redirects instruction fetch. Owns the PC, drives a req/ready instruction-memory port, hands words into
//  IF/ID with valid/stall, and flushes IF/ID on a taken branch or jump. No delay slot by default.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  DELAY_SLOT  0              1: keep the sequential word after a taken branch (no flush); 0: flush it
// PORTS
//  clk            in   1   single clock; all state changes on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  stall_i        in   1   hazard unit freezes IF/ID and PC
//  br_valid_i     in   1   ID holds a control instruction (beq/bne/bgt/ble/j/jal/jr) this cycle
//  is_branch_i    in   1   comparator decision: 1 = taken
//  br_target_i    in   32  target address for a taken branch
//  imem_req_o     out  1   fetch request
//  imem_addr_o    out  32  fetch address; stable while imem_req_o=1 and imem_ready_i=0
//  imem_ready_i   in   1   memory returns imem_rdata_i this cycle
//  imem_rdata_i   in   32  instruction word
//  if_valid_o     out  1   if_pc_o/if_instr_o written into IF/ID this cycle (1-cycle pulse per word)
//  if_pc_o        out  32  PC of delivered word
//  if_instr_o     out  32  delivered word
//  flush_o        out  1   kill IF/ID content (1-cycle pulse)
//  misalign_o     out  1   sticky: a target with bits[1:0]!=0 was accepted
// BEHAVIOUR
//  Reset (async, rst_n=0): state=BOOT, pc=RESET_PC, all outputs 0, redirect-pending cleared, hold buffer empty.
//  Redirect event = br_valid_i & is_branch_i & ~stall_i. While stall_i=1, br_valid_i is ignored (ID re-evaluates).
//  Target used = {br_target_i[31:2],2'b00}; misalign_o set if br_target_i[1:0]!=0, cleared only by reset.
//  flush_o = redirect event registered (asserted the cycle after the event) when DELAY_SLOT=0; always 0 otherwise.
//  States:
//   BOOT : imem_req_o=0; any imem_ready_i ignored; next cycle -> FETCH.
//   FETCH: imem_req_o=1, imem_addr_o=pc.
//    - redirect event, no ready: pend<=1, pend_tgt<=target (newer event overwrites); addr held.
//    - ready & (pend | redirect event): word dropped; pc<=newest target; pend<=0; stay FETCH.
//    - ready & stall_i: word+pc into hold buffer; pc<=pc+4 -> HOLD.
//    - ready & ~stall_i: next cycle if_valid_o=1 with pc/word; pc<=pc+4; stay FETCH.
//   HOLD : imem_req_o=0. stall_i=1: wait. stall_i=0 & redirect event: buffer dropped, pc<=target -> FETCH.
//          stall_i=0 otherwise: next cycle if_valid_o=1 with buffered pc/word -> FETCH.
//  Latency: ready -> if_valid_o = 1 cycle; redirect event -> imem_addr_o=target = 1 cycle (if no fetch outstanding).
//  pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0), no error.
//  if_pc_o/if_instr_o hold last delivered value when if_valid_o=0.
//  Reset mid-fetch: request dropped immediately; late ready in BOOT discarded.
// STRUCTURE
//  Shared package mips_pkg: RESET_PC default, fetch state encoding (BOOT/FETCH/HOLD), comparator
//  branch-code constants (000 beq, 001 bne, 010 bgt, 011 ble, 100 j/jal/jr), INSTR_W=32.
//  One sub-module: if_hold_buf (single-entry pc+instr register with load/clear/valid).
// TESTING
//  1 reset release, imem_ready 1 cycle after each req -> addrs 0,4,8; if_valid pulses with pc 0,4,8.
//  2 taken beq at ID, target 32'h40, no fetch outstanding -> flush_o 1 cycle; next imem_addr_o=32'h40.
//  3 redirect while fetch to 32'h10 pending, ready 2 cycles later -> word dropped, no if_valid; next addr=target.
//  4 ready with stall_i=1 for 3 cycles -> HOLD, req low; on release if_valid with held pc/word, fetch pc+4.
//  5 br_valid&is_branch with stall_i=1 -> no redirect/flush; target 32'h43 later -> addr 32'h40, misalign_o=1.
//  6 pc=32'hFFFF_FFFC -> next addr 0; rst_n low mid-fetch -> outputs 0, restart at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants.
// Fetch state encoding, branch codes, reset PC default.
package mips_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [2:0] BR_BEQ = 3'b000;
  localparam logic [2:0] BR_BNE = 3'b001;
  localparam logic [2:0] BR_BGT = 3'b010;
  localparam logic [2:0] BR_BLE = 3'b011;
  localparam logic [2:0] BR_JMP = 3'b100;

  function automatic logic [31:0] align_tgt(
    input logic [31:0] t
  );
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_if.sv
// Instruction-memory request/ready port.
// master = fetch unit, slave = memory.
interface fetch_redirect_if;
  import mips_pkg::*;

  logic               imem_req_o;
  logic [31:0]        imem_addr_o;
  logic               imem_ready_i;
  logic [INSTR_W-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_hold_buf.sv
// Single-entry pc+instr buffer for words
// that arrive while IF/ID is stalled.
module if_hold_buf
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [31:0]        pc_d,
  input  logic [INSTR_W-1:0] instr_d,
  output logic               valid,
  output logic [31:0]        pc_q,
  output logic [INSTR_W-1:0] instr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// IF-stage PC sequencer: fetches, buffers on
// stall, and redirects on taken branches.
module fetch_redirect
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               br_valid_i,
  input  logic               is_branch_i,
  input  logic [31:0]        br_target_i,
  fetch_redirect_if.master   imem,
  output logic               if_valid_o,
  output logic [31:0]        if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic               flush_o,
  output logic               misalign_o
);

  fetch_state_e state, state_nxt;

  logic        redir;
  logic [31:0] tgt;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_tgt;
  logic        rdy;
  logic        hold_load;
  logic        hold_clr;
  logic        hold_vld;
  logic [31:0] hold_pc;
  logic [INSTR_W-1:0] hold_instr;

  // stall masks the comparator: ID re-evaluates once released
  assign redir = br_valid_i & is_branch_i & ~stall_i;
  assign tgt   = align_tgt(br_target_i);
  assign rdy   = imem.imem_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: if (rdy & ~pend & ~redir & stall_i)
               state_nxt = HOLD;
      HOLD:  if (~stall_i) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem.imem_req_o  = 1'b0;
    imem.imem_addr_o = '0;
    hold_load        = 1'b0;
    hold_clr         = 1'b0;
    unique case (state)
      FETCH: begin
        imem.imem_req_o  = 1'b1;
        imem.imem_addr_o = pc;
        hold_load = rdy & ~pend & ~redir & stall_i;
      end
      HOLD: hold_clr = ~stall_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      pend       <= 1'b0;
      pend_tgt   <= '0;
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_instr_o <= '0;
      flush_o    <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      flush_o    <= redir & ~DELAY_SLOT;
      if (redir & (br_target_i[1:0] != 2'b00))
        misalign_o <= 1'b1;
      unique case (state)
        BOOT: if (redir) pc <= tgt;
        FETCH: begin
          if (rdy) begin
            if (pend | redir) begin
              pc   <= redir ? tgt : pend_tgt;
              pend <= 1'b0;
            end else begin
              pc <= pc + 32'd4;
              if (~stall_i) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pc;
                if_instr_o <= imem.imem_rdata_i;
              end
            end
          end else if (redir) begin
            pend     <= 1'b1;
            pend_tgt <= tgt;
          end
        end
        HOLD: begin
          if (~stall_i) begin
            if (redir) begin
              pc <= tgt;
            end else if (hold_vld) begin
              if_valid_o <= 1'b1;
              if_pc_o    <= hold_pc;
              if_instr_o <= hold_instr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  if_hold_buf u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hold_load),
    .clear   (hold_clr),
    .pc_d    (pc),
    .instr_d (imem.imem_rdata_i),
    .valid   (hold_vld),
    .pc_q    (hold_pc),
    .instr_q (hold_instr)
  );

endmodule

// File: tb/tb_fetch_redirect.sv
// Scoreboard bench for fetch_redirect:
// delivered words checked against a queue.
module tb_fetch_redirect;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        br_valid_i;
  logic        is_branch_i;
  logic [31:0] br_target_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        flush_o;
  logic        misalign_o;

  fetch_redirect_if imem();

  fetch_redirect dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .br_valid_i  (br_valid_i),
    .is_branch_i (is_branch_i),
    .br_target_i (br_target_i),
    .imem        (imem),
    .if_valid_o  (if_valid_o),
    .if_pc_o     (if_pc_o),
    .if_instr_o  (if_instr_o),
    .flush_o     (flush_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_w;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  always @(negedge clk) begin
    if (if_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_valid", {32'd0, if_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_w = sb.pop_front();
        chk("if_pc", {32'd0, if_pc_o}, {32'd0, exp_w[63:32]});
        chk("if_instr", {32'd0, if_instr_o}, {32'd0, exp_w[31:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] a);
    chk({tag, "_req"}, {63'd0, imem.imem_req_o}, 64'd1);
    chk({tag, "_addr"}, {32'd0, imem.imem_addr_o}, {32'd0, a});
  endtask

  task automatic fetch(input logic [31:0] a);
    imem.imem_ready_i = 1'b0;
    @(negedge clk);
    chk_addr("fetch", a);
    step();
    imem.imem_ready_i = 1'b1;
    imem.imem_rdata_i = word_of(a);
    sb.push_back({a, word_of(a)});
    step();
    imem.imem_ready_i = 1'b0;
  endtask

  task automatic redirect_on_ready(
    input logic [31:0] a,
    input logic [31:0] t
  );
    imem.imem_ready_i = 1'b0;
    @(negedge clk);
    chk_addr("redir_pre", a);
    step();
    imem.imem_ready_i = 1'b1;
    imem.imem_rdata_i = 32'hDEAD_BEEF;
    br_valid_i  = 1'b1;
    is_branch_i = 1'b1;
    br_target_i = t;
    step();
    imem.imem_ready_i = 1'b0;
    br_valid_i  = 1'b0;
    is_branch_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0;
    br_valid_i = 1'b0;
    is_branch_i = 1'b0;
    br_target_i = '0;
    imem.imem_ready_i = 1'b0;
    imem.imem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {63'd0, imem.imem_req_o}, 64'd0);
    chk("rst_addr", {32'd0, imem.imem_addr_o}, 64'd0);
    chk("rst_valid", {63'd0, if_valid_o}, 64'd0);
    chk("rst_flush", {63'd0, flush_o}, 64'd0);
    chk("rst_mis", {63'd0, misalign_o}, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_req", {63'd0, imem.imem_req_o}, 64'd0);
    step();

    // sequential fetch
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);

    // taken branch with ready: word dropped, addr = target
    redirect_on_ready(32'hC, 32'h40);
    @(negedge clk);
    chk("br_flush", {63'd0, flush_o}, 64'd1);
    chk_addr("br_tgt", 32'h40);
    fetch(32'h40);

    // redirect while fetch to 0x10 outstanding
    redirect_on_ready(32'h44, 32'h10);
    br_valid_i = 1'b1;
    is_branch_i = 1'b1;
    br_target_i = 32'h80;
    @(negedge clk);
    chk_addr("pend_a", 32'h10);
    step();
    br_valid_i = 1'b0;
    is_branch_i = 1'b0;
    @(negedge clk);
    chk_addr("pend_hold", 32'h10);
    chk("pend_flush", {63'd0, flush_o}, 64'd1);
    step();
    imem.imem_ready_i = 1'b1;
    imem.imem_rdata_i = 32'hBAD0_0010;
    @(negedge clk);
    chk("flush_pulse", {63'd0, flush_o}, 64'd0);
    step();
    imem.imem_ready_i = 1'b0;
    @(negedge clk);
    chk_addr("pend_tgt", 32'h80);
    fetch(32'h80);

    // stall on ready: word parked in HOLD
    @(negedge clk);
    chk_addr("stall_pre", 32'h84);
    step();
    imem.imem_ready_i = 1'b1;
    imem.imem_rdata_i = word_of(32'h84);
    stall_i = 1'b1;
    step();
    imem.imem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_req", {63'd0, imem.imem_req_o}, 64'd0);
      step();
    end
    stall_i = 1'b0;
    sb.push_back({32'h84, word_of(32'h84)});
    step();
    @(negedge clk);
    chk_addr("hold_next", 32'h88);

    // branch during stall ignored; misaligned target later
    step();
    stall_i = 1'b1;
    br_valid_i = 1'b1;
    is_branch_i = 1'b1;
    br_target_i = 32'h43;
    step();
    stall_i = 1'b0;
    br_valid_i = 1'b0;
    is_branch_i = 1'b0;
    @(negedge clk);
    chk("stall_noflush", {63'd0, flush_o}, 64'd0);
    chk("stall_nomis", {63'd0, misalign_o}, 64'd0);
    chk_addr("stall_noredir", 32'h88);
    redirect_on_ready(32'h88, 32'h43);
    @(negedge clk);
    chk_addr("mis_tgt", 32'h40);
    chk("mis_set", {63'd0, misalign_o}, 64'd1);
    chk("mis_flush", {63'd0, flush_o}, 64'd1);

    // wrap and reset mid-fetch
    redirect_on_ready(32'h40, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC);
    @(negedge clk);
    chk_addr("wrap", 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_req", {63'd0, imem.imem_req_o}, 64'd0);
    chk("mid_addr", {32'd0, imem.imem_addr_o}, 64'd0);
    chk("mid_valid", {63'd0, if_valid_o}, 64'd0);
    chk("mid_mis", {63'd0, misalign_o}, 64'd0);
    step();
    rst_n = 1'b1;
    imem.imem_ready_i = 1'b1;
    imem.imem_rdata_i = 32'hBAD0_B007;
    @(negedge clk);
    chk("late_req", {63'd0, imem.imem_req_o}, 64'd0);
    step();
    fetch(32'h0);
    repeat (2) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
